// File: rtl/dcache_dm_if.sv
// dcache_dm_if: word-wide valid/ready bus between the data cache and main memory.
interface dcache_dm_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through no-write-allocate data cache for the M stage.
// Load misses fill a whole block beat by beat; every store goes straight to memory.
module dcache_dm #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    dcache_dm_if.master bus
);
    localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [SETS-1:0]        valid_q;
    logic [TAG_BITS-1:0]    tag_q  [SETS];
    logic [31:0]            data_q [SETS*WORDS];
    logic [31:0]            addr_q, wdata_q, hit_cnt_q, miss_cnt_q;
    logic [OFFSET_BITS-1:0] beat_q;
    logic                   refill_q;

    logic [INDEX_BITS-1:0]  idx, a_idx;
    logic [OFFSET_BITS-1:0] off, a_off;
    logic [TAG_BITS-1:0]    tag, a_tag;
    logic                   idle, load, hit, miss, beat_done, last, wr_hit;

    assign off   = cpu_addr[OFFSET_BITS+1:2];
    assign idx   = cpu_addr[OFFSET_BITS+2 +: INDEX_BITS];
    assign tag   = cpu_addr[31 -: TAG_BITS];
    assign a_off = addr_q[OFFSET_BITS+1:2];
    assign a_idx = addr_q[OFFSET_BITS+2 +: INDEX_BITS];
    assign a_tag = addr_q[31 -: TAG_BITS];

    assign idle      = state_q == IDLE;
    assign load      = cpu_rd & ~cpu_wr;
    assign hit       = valid_q[idx] && tag_q[idx] == tag;
    assign miss      = idle && load && !hit;
    assign beat_done = state_q == FILL && bus.mem_ready;
    assign last      = beat_done && &beat_q;
    assign wr_hit    = valid_q[a_idx] && tag_q[a_idx] == a_tag;

    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                state_d   = cpu_wr ? WRITE : miss ? FILL : IDLE;
                cpu_stall = cpu_wr | miss;
            end
            FILL: begin
                state_d   = last ? IDLE : FILL;
                cpu_stall = 1'b1;
            end
            WRITE: begin
                state_d   = bus.mem_ready ? IDLE : WRITE;
                cpu_stall = ~bus.mem_ready;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req   = !idle;
    assign bus.mem_we    = state_q == WRITE;
    assign bus.mem_addr  = state_q == FILL ? {addr_q[31:OFFSET_BITS+2], beat_q, 2'b00} : {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign cpu_rdata     = (idle && load && hit) ? data_q[{idx, off}] : '0;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat_q     <= '0;
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            // the replayed lookup right after a fill was already counted as a miss
            refill_q <= last;
            if (idle && (cpu_wr || miss)) addr_q <= cpu_addr;
            if (idle && cpu_wr) wdata_q <= cpu_wdata;
            // drop the old line up front so an aborted fill can never look valid
            if (miss) begin
                beat_q       <= '0;
                valid_q[idx] <= 1'b0;
            end
            if (beat_done) beat_q <= beat_q + 1'b1;
            if (last) valid_q[a_idx] <= 1'b1;
            if (idle && load && hit && !refill_q && ~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss && ~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_done) data_q[{a_idx, beat_q}] <= bus.mem_rdata;
        if (state_q == WRITE && bus.mem_ready && wr_hit) data_q[{a_idx, a_off}] <= wdata_q;
        if (last) tag_q[a_idx] <= a_tag;
    end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed scenarios for dcache_dm against a memory responder whose
// first beat of each request waits lat0 cycles and later beats wait latn cycles.
module tb_dcache_dm;
    logic        clk = 1'b0, rst = 1'b1, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata, hit_count, miss_count;
    logic        cpu_stall;
    int          checks = 0, errors = 0;
    int          lat0 = 1, latn = 0, k = 0, bnum = 0, req_cycles = 0;
    logic [31:0] memory [logic [31:0]];
    logic [31:0] log_addr[$], log_data[$];
    logic        log_we[$];

    dcache_dm_if bus();

    dcache_dm dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .hit_count(hit_count), .miss_count(miss_count), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return memory.exists(a) ? memory[a] : 32'hA000_0000 + a;
    endfunction

    initial begin : responder
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req) begin
                bus.mem_ready = 1'b0;
                k = 0;
                bnum = 0;
            end else begin
                req_cycles++;
                bus.mem_ready = (k == (bnum == 0 ? lat0 : latn));
                if (bus.mem_ready) begin
                    log_addr.push_back(bus.mem_addr);
                    log_we.push_back(bus.mem_we);
                    log_data.push_back(bus.mem_wdata);
                    if (bus.mem_we) memory[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = rd_word(bus.mem_addr);
                    k = 0;
                    bnum++;
                end else k++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
        req_cycles = 0;
    endtask

    task automatic do_load(input logic [31:0] a, output int n, output logic [31:0] d);
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = a;
        #1;
        n = 0;
        while (cpu_stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        d = cpu_rdata;
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] v, input logic rd_too, output int n);
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_rd = rd_too;
        cpu_addr = a;
        cpu_wdata = v;
        #1;
        n = 0;
        while (cpu_stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_quiet: got stall %b req %b want 0 0", cpu_stall, bus.mem_req); end
        checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL idle_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_miss_fill();
        int n;
        logic [31:0] d;
        lat0 = 1; latn = 0;
        clear_log();
        do_load(32'h100, n, d);
        checks++; if (n !== 6) begin errors++; $display("FAIL fill_stall_cycles: got %0d want 6", n); end
        checks++; if (d !== 32'hA000_0100) begin errors++; $display("FAIL fill_rdata: got %h want a0000100", d); end
        checks++; if (log_addr.size() !== 4) begin errors++; $display("FAIL fill_beats: got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++; if (log_addr[i] !== 32'h100 + 32'(4 * i) || log_we[i] !== 1'b0) begin errors++; $display("FAIL fill_beat%0d: got addr %h we %b want %h 0", i, log_addr[i], log_we[i], 32'h100 + 32'(4 * i)); end
        end
        checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin errors++; $display("FAIL fill_counters: got hit %0d miss %0d want 0 1", hit_count, miss_count); end
    endtask

    task automatic test_hit();
        int n;
        logic [31:0] d;
        clear_log();
        do_load(32'h108, n, d);
        checks++; if (n !== 0) begin errors++; $display("FAIL hit_stall: got %0d want 0", n); end
        checks++; if (d !== 32'hA000_0108) begin errors++; $display("FAIL hit_rdata: got %h want a0000108", d); end
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL hit_counters: got hit %0d miss %0d want 1 1", hit_count, miss_count); end
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL hit_no_mem: got %0d req cycles want 0", req_cycles); end
    endtask

    task automatic test_store_hit();
        int n;
        logic [31:0] d;
        lat0 = 3;
        clear_log();
        do_store(32'h108, 32'hDEAD_BEEF, 1'b0, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL st_stall_cycles: got %0d want 4", n); end
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL st_req_cycles: got %0d want 4", req_cycles); end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL st_beats: got %0d want 1", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'h108 || log_we[0] !== 1'b1 || log_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_beat: got %h %b %h want 108 1 deadbeef", log_addr[0], log_we[0], log_data[0]); end
        end
        lat0 = 1;
        do_load(32'h108, n, d);
        checks++; if (n !== 0 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_reload: got stall %0d data %h want 0 deadbeef", n, d); end
        checks++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin errors++; $display("FAIL st_counters: got hit %0d miss %0d want 2 1", hit_count, miss_count); end
    endtask

    task automatic test_store_miss();
        int n;
        logic [31:0] d;
        lat0 = 0;
        clear_log();
        do_store(32'h300, 32'h11, 1'b0, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL stm_stall: got %0d want 1", n); end
        checks++; if (log_addr.size() !== 1 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h300) begin errors++; $display("FAIL stm_single_write: got %0d beats want 1 write to 300", log_addr.size()); end
        lat0 = 1;
        clear_log();
        do_load(32'h300, n, d);
        checks++; if (n !== 6 || d !== 32'h11) begin errors++; $display("FAIL stm_no_alloc: got stall %0d data %h want 6 11", n, d); end
        checks++; if (miss_count !== 32'd2 || hit_count !== 32'd2) begin errors++; $display("FAIL stm_counters: got hit %0d miss %0d want 2 2", hit_count, miss_count); end
    endtask

    task automatic test_evict();
        int n;
        logic [31:0] d;
        do_load(32'h100, n, d);
        checks++; if (n !== 6 || miss_count !== 32'd3) begin errors++; $display("FAIL ev_load100: got stall %0d miss %0d want 6 3", n, miss_count); end
        do_load(32'h100, n, d);
        checks++; if (n !== 0 || hit_count !== 32'd3) begin errors++; $display("FAIL ev_hit100: got stall %0d hit %0d want 0 3", n, hit_count); end
        do_load(32'h200, n, d);
        checks++; if (n !== 6 || d !== 32'hA000_0200 || miss_count !== 32'd4) begin errors++; $display("FAIL ev_load200: got stall %0d data %h miss %0d want 6 a0000200 4", n, d, miss_count); end
        do_load(32'h100, n, d);
        checks++; if (n !== 6 || d !== 32'hA000_0100 || miss_count !== 32'd5) begin errors++; $display("FAIL ev_reload100: got stall %0d data %h miss %0d want 6 a0000100 5", n, d, miss_count); end
    endtask

    task automatic test_rd_wr_conflict();
        int n;
        logic [31:0] d;
        lat0 = 0;
        clear_log();
        do_store(32'h104, 32'h55, 1'b1, n);
        checks++; if (n !== 1 || log_addr.size() !== 1 || log_we[0] !== 1'b1) begin errors++; $display("FAIL cf_store_wins: got stall %0d beats %0d want 1 1", n, log_addr.size()); end
        checks++; if (hit_count !== 32'd3 || miss_count !== 32'd5) begin errors++; $display("FAIL cf_counters: got hit %0d miss %0d want 3 5", hit_count, miss_count); end
        lat0 = 1;
        do_load(32'h104, n, d);
        checks++; if (n !== 0 || d !== 32'h55) begin errors++; $display("FAIL cf_reload: got stall %0d data %h want 0 55", n, d); end
    endtask

    task automatic test_reset_mid_fill();
        int n, t;
        logic [31:0] d;
        lat0 = 1; latn = 0;
        clear_log();
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 32'h204;
        t = 0;
        while (log_addr.size() < 3 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++; if (log_addr.size() !== 3 || bus.mem_addr !== 32'h208) begin errors++; $display("FAIL rf_reach_beat2: got %0d beats addr %h want 3 208", log_addr.size(), bus.mem_addr); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rf_req_drop: got %b want 0", bus.mem_req); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rf_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_load(32'h100, n, d);
        checks++; if (n !== 6 || d !== 32'hA000_0100 || miss_count !== 32'd1) begin errors++; $display("FAIL rf_reload: got stall %0d data %h miss %0d want 6 a0000100 1", n, d, miss_count); end
        do_load(32'h204, n, d);
        checks++; if (n !== 6 || d !== 32'hA000_0204) begin errors++; $display("FAIL rf_partial_invalid: got stall %0d data %h want 6 a0000204", n, d); end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_evict();
        test_rd_wr_conflict();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
